layer_priority_mux: RTL

LAYER_PRIORITY_MUX -- requirements
Module: layer_priority_mux

---
 rtl/layer_priority_mux_if.sv | 27 ++
 rtl/layer_priority_mux.sv | 59 +++++
 2 files changed

// File: rtl/layer_priority_mux_if.sv
// layer_priority_mux_if: pixel-layer bus between the layer sources and the compositor.
// master: drives layer_dr, layer_rgb, layer_en, start_of_frame and receives the composited outputs.
// slave:  the compositor side, receiving the layer inputs and driving out_dr, out_rgb, out_layer,
//         collision_pulse and frame_collision.
interface layer_priority_mux_if #(
  parameter int NUM_LAYERS = 4,
  parameter int COLOR_W = 8
);
  localparam int LW = $clog2(NUM_LAYERS);
  logic [NUM_LAYERS-1:0] layer_dr;
  logic [NUM_LAYERS*COLOR_W-1:0] layer_rgb;
  logic [NUM_LAYERS-1:0] layer_en;
  logic start_of_frame;
  logic out_dr;
  logic [COLOR_W-1:0] out_rgb;
  logic [LW-1:0] out_layer;
  logic collision_pulse;
  logic [NUM_LAYERS-1:0] frame_collision;
  modport master (
    output layer_dr, layer_rgb, layer_en, start_of_frame,
    input out_dr, out_rgb, out_layer, collision_pulse, frame_collision
  );
  modport slave (
    input layer_dr, layer_rgb, layer_en, start_of_frame,
    output out_dr, out_rgb, out_layer, collision_pulse, frame_collision
  );
endinterface

// File: rtl/layer_priority_mux.sv
// layer_priority_mux: fixed-priority layer compositor with per-frame collision flags.
// clk:    pixel clock.
// resetN: asynchronous active-low reset.
// bus:    slave side of layer_priority_mux_if (layer inputs in, registered composite out).
module layer_priority_mux #(
  parameter int NUM_LAYERS = 4,
  parameter int COLOR_W = 8,
  parameter logic [COLOR_W-1:0] BG_RGB = '0
) (
  input logic clk,
  input logic resetN,
  layer_priority_mux_if.slave bus
);
  localparam int LW = $clog2(NUM_LAYERS);
  logic [NUM_LAYERS-1:0] en_sh_q, en_sh_d, cur_col_q, cur_col_d, frame_col_q, frame_col_d;
  logic [NUM_LAYERS-1:0] eff, col_hit;
  logic out_dr_q, out_dr_d, col_q, col_d, multi;
  logic [COLOR_W-1:0] out_rgb_q, out_rgb_d;
  logic [LW-1:0] out_layer_q, out_layer_d, win;
  always_comb begin
    eff = bus.layer_dr & en_sh_q;
    win = '0;
    for (int i = NUM_LAYERS-1; i >= 0; i--) win = eff[i] ? LW'(i) : win;
    // clearing the lowest set bit leaves something behind only when two or more bits are set
    multi = (eff & (eff - NUM_LAYERS'(1))) != '0;
    col_hit = multi ? eff : '0;
    out_dr_d = |eff;
    // only the winner's slice is read, and only when a layer actually draws
    out_rgb_d = out_dr_d ? bus.layer_rgb[int'(win)*COLOR_W +: COLOR_W] : BG_RGB;
    out_layer_d = out_dr_d ? win : '0;
    col_d = multi;
    en_sh_d = bus.start_of_frame ? bus.layer_en : en_sh_q;
    cur_col_d = bus.start_of_frame ? col_hit : cur_col_q | col_hit;
    frame_col_d = bus.start_of_frame ? cur_col_q : frame_col_q;
  end
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      en_sh_q <= '1;
      cur_col_q <= '0;
      frame_col_q <= '0;
      out_dr_q <= 1'b0;
      out_rgb_q <= BG_RGB;
      out_layer_q <= '0;
      col_q <= 1'b0;
    end else begin
      en_sh_q <= en_sh_d;
      cur_col_q <= cur_col_d;
      frame_col_q <= frame_col_d;
      out_dr_q <= out_dr_d;
      out_rgb_q <= out_rgb_d;
      out_layer_q <= out_layer_d;
      col_q <= col_d;
    end
  assign bus.out_dr = out_dr_q;
  assign bus.out_rgb = out_rgb_q;
  assign bus.out_layer = out_layer_q;
  assign bus.collision_pulse = col_q;
  assign bus.frame_collision = frame_col_q;
endmodule
